// File: rtl/burst_ram_arbiter_pkg.sv
// Shared command codes, burst length and one-hot FSM encoding for the burst RAM arbiter.
package burst_ram_arbiter_pkg;

  localparam logic BR_CMD_READ  = 1'b0;
  localparam logic BR_CMD_WRITE = 1'b1;
  localparam int   BURST_BEATS  = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    RD_WAIT  = 3'b010,
    WR_BEATS = 3'b100
  } state_t;

endpackage

// File: rtl/burst_ram_arbiter_request_buffer.sv
// One client's request buffer: captures a whole burst request (command, address,
// mask and all write beats) so it can be replayed later, and reads beats out by index.
module burst_ram_request_buffer
  import burst_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_en,
  input  logic              cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wr_data,
  input  logic [7:0]        data_mask,
  input  logic              done,
  input  logic [1:0]        beat_sel,
  output logic              valid,
  output logic              held_cmd,
  output logic [ADDR_W-1:0] held_addr,
  output logic [7:0]        held_mask,
  output logic [63:0]       held_beat
);

  logic [1:0]                   cap_cnt;
  logic [BURST_BEATS-1:0][63:0] beats;
  logic                         capture;

  // A pulse while already holding a request is dropped without touching any state.
  assign capture   = cmd_en && !valid;
  assign held_beat = beats[beat_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid     <= 1'b0;
      held_cmd  <= 1'b0;
      held_addr <= '0;
      held_mask <= '0;
      beats     <= '0;
      cap_cnt   <= 2'd0;
    end else if (capture) begin
      valid     <= 1'b1;
      held_cmd  <= cmd;
      held_addr <= addr;
      held_mask <= data_mask;
      beats[0]  <= wr_data;
      cap_cnt   <= (cmd == BR_CMD_WRITE) ? 2'd1 : 2'd0;
    end else begin
      if (done) begin
        valid <= 1'b0;
      end
      // Trailing write beats arrive on the three cycles after the pulse; counter wraps to 0 when done.
      if (cap_cnt != 2'd0) begin
        beats[cap_cnt] <= wr_data;
        cap_cnt        <= cap_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Shares one burst RAM port between two cache clients, replaying buffered bursts whole.
// Define BURST_RAM_ARBITER_FIXED_PRIORITY_EN for fixed client-0 priority instead of round-robin.
module burst_ram_arbiter
  import burst_ram_arbiter_pkg::*;
#(
  parameter int BURST_RAM_DEPTH_BITWIDTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                c0_cmd,
  input  logic                                c0_cmd_en,
  input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] c0_addr,
  input  logic [63:0]                         c0_wr_data,
  input  logic [7:0]                          c0_data_mask,
  output logic [63:0]                         c0_rd_data,
  output logic                                c0_rd_data_ready,
  output logic                                c0_busy,
  input  logic                                c1_cmd,
  input  logic                                c1_cmd_en,
  input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] c1_addr,
  input  logic [63:0]                         c1_wr_data,
  input  logic [7:0]                          c1_data_mask,
  output logic [63:0]                         c1_rd_data,
  output logic                                c1_rd_data_ready,
  output logic                                c1_busy,
  output logic                                br_cmd,
  output logic                                br_cmd_en,
  output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]                         br_wr_data,
  output logic [7:0]                          br_data_mask,
  input  logic [63:0]                         br_rd_data,
  input  logic                                br_rd_data_ready,
  input  logic                                br_busy
);

  localparam int         AW        = BURST_RAM_DEPTH_BITWIDTH;
  localparam logic [1:0] LAST_BEAT = 2'(BURST_BEATS - 1);

  state_t        state, state_next;
  logic          grant, grant_next, pick;
  logic [1:0]    beat_cnt, beat_cnt_next, beat_sel;
  logic          issue, complete;
  logic [1:0]    buf_valid, buf_cmd, buf_done;
  logic [AW-1:0] buf_addr [2];
  logic [7:0]    buf_mask [2];
  logic [63:0]   buf_beat [2];
  logic          cmd_en_d, cmd_d;
  logic [AW-1:0] addr_d;
  logic [7:0]    mask_d;
  logic [63:0]   wr_data_d;

  // Beat 0 is always read while idle so the command cycle carries the first write beat.
  assign beat_sel = (state == WR_BEATS) ? beat_cnt : 2'd0;
  assign buf_done = {complete && grant, complete && !grant};

  burst_ram_request_buffer #(.ADDR_W(AW)) u_buf0 (
    .clk(clk), .rst(rst), .cmd_en(c0_cmd_en), .cmd(c0_cmd), .addr(c0_addr),
    .wr_data(c0_wr_data), .data_mask(c0_data_mask), .done(buf_done[0]), .beat_sel(beat_sel),
    .valid(buf_valid[0]), .held_cmd(buf_cmd[0]), .held_addr(buf_addr[0]),
    .held_mask(buf_mask[0]), .held_beat(buf_beat[0])
  );

  burst_ram_request_buffer #(.ADDR_W(AW)) u_buf1 (
    .clk(clk), .rst(rst), .cmd_en(c1_cmd_en), .cmd(c1_cmd), .addr(c1_addr),
    .wr_data(c1_wr_data), .data_mask(c1_data_mask), .done(buf_done[1]), .beat_sel(beat_sel),
    .valid(buf_valid[1]), .held_cmd(buf_cmd[1]), .held_addr(buf_addr[1]),
    .held_mask(buf_mask[1]), .held_beat(buf_beat[1])
  );

  assign c0_busy          = buf_valid[0];
  assign c1_busy          = buf_valid[1];
  assign c0_rd_data       = br_rd_data;
  assign c1_rd_data       = br_rd_data;
  assign c0_rd_data_ready = (state == RD_WAIT) && !grant && br_rd_data_ready;
  assign c1_rd_data_ready = (state == RD_WAIT) &&  grant && br_rd_data_ready;

  assign issue    = (state == IDLE) && (|buf_valid) && !br_busy;
  assign complete = ((state == RD_WAIT) && br_rd_data_ready && (beat_cnt == LAST_BEAT)) ||
                    ((state == WR_BEATS) && (beat_cnt == LAST_BEAT));

`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
  assign pick = buf_valid[0] ? 1'b0 : 1'b1;
`else
  logic rr_ptr;

  assign pick = (&buf_valid) ? rr_ptr : buf_valid[1];

  // After each burst the other client gets first claim on a contested grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (complete) begin
      rr_ptr <= ~grant;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= 1'b0;
      beat_cnt     <= 2'd0;
      br_cmd_en    <= 1'b0;
      br_cmd       <= 1'b0;
      br_addr      <= '0;
      br_data_mask <= '0;
      br_wr_data   <= '0;
    end else begin
      state        <= state_next;
      grant        <= grant_next;
      beat_cnt     <= beat_cnt_next;
      br_cmd_en    <= cmd_en_d;
      br_cmd       <= cmd_d;
      br_addr      <= addr_d;
      br_data_mask <= mask_d;
      br_wr_data   <= wr_data_d;
    end
  end

  always_comb begin
    state_next    = state;
    grant_next    = grant;
    beat_cnt_next = beat_cnt;
    case (state)
      IDLE: begin
        if (issue) begin
          grant_next    = pick;
          state_next    = (buf_cmd[pick] == BR_CMD_WRITE) ? WR_BEATS : RD_WAIT;
          beat_cnt_next = (buf_cmd[pick] == BR_CMD_WRITE) ? 2'd1 : 2'd0;
        end
      end
      RD_WAIT: begin
        if (br_rd_data_ready) begin
          beat_cnt_next = beat_cnt + 2'd1;
          if (beat_cnt == LAST_BEAT) state_next = IDLE;
        end
      end
      WR_BEATS: begin
        beat_cnt_next = beat_cnt + 2'd1;
        if (beat_cnt == LAST_BEAT) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_en_d  = 1'b0;
    cmd_d     = br_cmd;
    addr_d    = br_addr;
    mask_d    = br_data_mask;
    wr_data_d = br_wr_data;
    if (issue) begin
      cmd_en_d  = 1'b1;
      cmd_d     = buf_cmd[pick];
      addr_d    = buf_addr[pick];
      mask_d    = buf_mask[pick];
      wr_data_d = buf_beat[pick];
    end else if (state == WR_BEATS) begin
      wr_data_d = buf_beat[grant];
    end
  end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed table-driven bench for burst_ram_arbiter; honours BURST_RAM_ARBITER_FIXED_PRIORITY_EN.
`timescale 1ns/1ps
module tb_burst_ram_arbiter;
  import burst_ram_arbiter_pkg::*;

  localparam int AW = 4;

  typedef struct {
    int              client;
    logic            cmd;
    logic [AW-1:0]   addr;
    logic [7:0]      mask;
    logic [3:0][63:0] beats;
    logic            exp_cmd;
    logic [AW-1:0]   exp_addr;
    logic [7:0]      exp_mask;
  } vec_t;

  logic clk, rst;
  logic [1:0]         c_cmd, c_cmd_en, rdy, busy;
  logic [1:0][AW-1:0] c_addr;
  logic [1:0][63:0]   c_wr_data, c_rd_data;
  logic [1:0][7:0]    c_mask;
  logic               br_cmd, br_cmd_en, br_rd_data_ready, br_busy;
  logic [AW-1:0]      br_addr;
  logic [63:0]        br_wr_data, br_rd_data;
  logic [7:0]         br_data_mask;

  int checks = 0;
  int errors = 0;

  burst_ram_arbiter #(.BURST_RAM_DEPTH_BITWIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .c0_cmd(c_cmd[0]), .c0_cmd_en(c_cmd_en[0]), .c0_addr(c_addr[0]), .c0_wr_data(c_wr_data[0]),
    .c0_data_mask(c_mask[0]), .c0_rd_data(c_rd_data[0]), .c0_rd_data_ready(rdy[0]), .c0_busy(busy[0]),
    .c1_cmd(c_cmd[1]), .c1_cmd_en(c_cmd_en[1]), .c1_addr(c_addr[1]), .c1_wr_data(c_wr_data[1]),
    .c1_data_mask(c_mask[1]), .c1_rd_data(c_rd_data[1]), .c1_rd_data_ready(rdy[1]), .c1_busy(busy[1]),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data), .br_rd_data_ready(br_rd_data_ready),
    .br_busy(br_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic vec_t mkVec(input int client, input logic cmd, input logic [AW-1:0] addr,
                                 input logic [7:0] mask, input logic [3:0][63:0] beats,
                                 input logic exp_cmd, input logic [AW-1:0] exp_addr,
                                 input logic [7:0] exp_mask);
    vec_t v;
    v.client = client; v.cmd = cmd; v.addr = addr; v.mask = mask; v.beats = beats;
    v.exp_cmd = exp_cmd; v.exp_addr = exp_addr; v.exp_mask = exp_mask;
    return v;
  endfunction

  // Drives one client's cmd_en pulse plus the three trailing beats, starting in the current cycle.
  task automatic applyStimulus(input vec_t v);
    c_cmd[v.client]     = v.cmd;
    c_cmd_en[v.client]  = 1'b1;
    c_addr[v.client]    = v.addr;
    c_mask[v.client]    = v.mask;
    c_wr_data[v.client] = v.beats[0];
    for (int k = 1; k < 4; k++) begin
      nextCycle();
      c_cmd_en[v.client]  = 1'b0;
      c_wr_data[v.client] = v.beats[k];
    end
    nextCycle();
    c_wr_data[v.client] = '0;
  endtask

  task automatic lateStimulus(input int delay, input vec_t v);
    repeat (delay) nextCycle();
    applyStimulus(v);
  endtask

  // Called at mid-cycle of the expected issue cycle; finishes at the start of the cycle after completion.
  task automatic serve(input vec_t v);
    int o;
    o = 1 - v.client;
    checkOutput("issue_en", 64'(br_cmd_en), 64'd1);
    checkOutput("issue_cmd", 64'(br_cmd), 64'(v.exp_cmd));
    checkOutput("issue_addr", 64'(br_addr), 64'(v.exp_addr));
    checkOutput("issue_mask", 64'(br_data_mask), 64'(v.exp_mask));
    if (v.exp_cmd == BR_CMD_WRITE) begin
      checkOutput("wr_beat0", br_wr_data, v.beats[0]);
      for (int k = 1; k < 4; k++) begin
        nextCycle();
        mid();
        checkOutput("wr_beat", br_wr_data, v.beats[k]);
        checkOutput("wr_cmd_en_low", 64'(br_cmd_en), 64'd0);
      end
      checkOutput("wr_busy_clear", 64'(busy[v.client]), 64'd0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        nextCycle();
        br_rd_data_ready = 1'b1;
        br_rd_data       = v.beats[k];
        mid();
        checkOutput("rd_ready_own", 64'(rdy[v.client]), 64'd1);
        checkOutput("rd_ready_other", 64'(rdy[o]), 64'd0);
        checkOutput("rd_data", c_rd_data[v.client], v.beats[k]);
        if (k == 3) checkOutput("rd_busy_held", 64'(busy[v.client]), 64'd1);
      end
      nextCycle();
      br_rd_data_ready = 1'b0;
      br_rd_data       = '0;
      mid();
      checkOutput("rd_busy_clear", 64'(busy[v.client]), 64'd0);
    end
    nextCycle();
  endtask

  task automatic waitIssue(input int limit);
    int n;
    n = 0;
    mid();
    while (br_cmd_en !== 1'b1 && n < limit) begin
      nextCycle();
      mid();
      n++;
    end
    if (br_cmd_en !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL issue_timeout: got no br_cmd_en, expected one within %0d cycles", limit);
    end
  endtask

  // Cycle-exact single transaction: pulse in cycle 0, command must appear in cycle 2.
  task automatic runVector(input vec_t v);
    fork
      applyStimulus(v);
    join_none
    mid();
    checkOutput("pre_busy", 64'(busy[v.client]), 64'd0);
    checkOutput("pre_cmd_en", 64'(br_cmd_en), 64'd0);
    nextCycle();
    mid();
    checkOutput("capture_busy", 64'(busy[v.client]), 64'd1);
    checkOutput("latency_cmd_en", 64'(br_cmd_en), 64'd0);
    nextCycle();
    mid();
    serve(v);
  endtask

  task automatic contest(input vec_t a, input vec_t b, input vec_t first, input vec_t second);
    fork
      applyStimulus(a);
      applyStimulus(b);
    join_none
    waitIssue(6);
    serve(first);
    waitIssue(6);
    serve(second);
  endtask

  task automatic checkReset();
    checkOutput("rst_cmd_en", 64'(br_cmd_en), 64'd0);
    checkOutput("rst_cmd", 64'(br_cmd), 64'd0);
    checkOutput("rst_addr", 64'(br_addr), 64'd0);
    checkOutput("rst_mask", 64'(br_data_mask), 64'd0);
    checkOutput("rst_wr_data", br_wr_data, 64'd0);
    checkOutput("rst_ready", 64'(rdy), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    nextCycle();
  endtask

  vec_t vectors [4];
  vec_t va, vb, vx;
  int   issues;

  initial begin
    rst = 1'b1;
    c_cmd = '0; c_cmd_en = '0; c_addr = '0; c_wr_data = '0; c_mask = '0;
    br_rd_data = '0; br_rd_data_ready = 1'b0; br_busy = 1'b0;
    nextCycle();
    mid();
    checkReset();
    nextCycle();
    rst = 1'b0;
    nextCycle();

    vectors[0] = mkVec(0, BR_CMD_READ, 4'd4, 8'hFF,
                       {64'h44, 64'h33, 64'h22, 64'h11}, BR_CMD_READ, 4'd4, 8'hFF);
    vectors[1] = mkVec(1, BR_CMD_WRITE, 4'd8, 8'hF0,
                       {64'hA3, 64'hA2, 64'hA1, 64'hA0}, BR_CMD_WRITE, 4'd8, 8'hF0);
    vectors[2] = mkVec(0, BR_CMD_WRITE, 4'd3, 8'h0F,
                       {64'hDDDD_0000_0000_0003, 64'hCCCC_0000_0000_0002,
                        64'hBBBB_0000_0000_0001, 64'hAAAA_0000_0000_0000}, BR_CMD_WRITE, 4'd3, 8'h0F);
    vectors[3] = mkVec(1, BR_CMD_READ, 4'd15, 8'h00,
                       {64'hFEED_FACE_0000_0004, 64'hCAFE_F00D_0000_0003,
                        64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_0000_0001}, BR_CMD_READ, 4'd15, 8'h00);
    for (int i = 0; i < 4; i++) begin
      $display("[TB] vector %0d", i);
      runVector(vectors[i]);
    end

    $display("[TB] contested rounds");
    resetDut();
    va = mkVec(0, BR_CMD_READ, 4'd0, 8'hFF, {64'h4, 64'h3, 64'h2, 64'h1}, BR_CMD_READ, 4'd0, 8'hFF);
    vb = mkVec(1, BR_CMD_WRITE, 4'd12, 8'h3C, {64'hB3, 64'hB2, 64'hB1, 64'hB0}, BR_CMD_WRITE, 4'd12, 8'h3C);
    contest(va, vb, va, vb);
    vx = mkVec(0, BR_CMD_WRITE, 4'd1, 8'h01, {64'hC3, 64'hC2, 64'hC1, 64'hC0}, BR_CMD_WRITE, 4'd1, 8'h01);
    fork applyStimulus(vx); join_none
    waitIssue(6);
    serve(vx);
    va = mkVec(0, BR_CMD_READ, 4'd2, 8'h11, {64'h24, 64'h23, 64'h22, 64'h21}, BR_CMD_READ, 4'd2, 8'h11);
    vb = mkVec(1, BR_CMD_READ, 4'd3, 8'h22, {64'h34, 64'h33, 64'h32, 64'h31}, BR_CMD_READ, 4'd3, 8'h22);
`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
    contest(va, vb, va, vb);
`else
    contest(va, vb, vb, va);
`endif
    vx = mkVec(1, BR_CMD_WRITE, 4'd9, 8'h80, {64'hE3, 64'hE2, 64'hE1, 64'hE0}, BR_CMD_WRITE, 4'd9, 8'h80);
    fork applyStimulus(vx); join_none
    waitIssue(6);
    serve(vx);
    va = mkVec(0, BR_CMD_WRITE, 4'd4, 8'h44, {64'h43, 64'h42, 64'h41, 64'h40}, BR_CMD_WRITE, 4'd4, 8'h44);
    vb = mkVec(1, BR_CMD_WRITE, 4'd5, 8'h55, {64'h53, 64'h52, 64'h51, 64'h50}, BR_CMD_WRITE, 4'd5, 8'h55);
    contest(va, vb, va, vb);

    $display("[TB] br_busy stall");
    br_busy = 1'b1;
    vx = mkVec(0, BR_CMD_WRITE, 4'd6, 8'h66, {64'h63, 64'h62, 64'h61, 64'h60}, BR_CMD_WRITE, 4'd6, 8'h66);
    fork applyStimulus(vx); join_none
    for (int i = 0; i < 10; i++) begin
      mid();
      checkOutput("stall_no_issue", 64'(br_cmd_en), 64'd0);
      nextCycle();
    end
    br_busy = 1'b0;
    mid();
    checkOutput("stall_fall_cycle", 64'(br_cmd_en), 64'd0);
    nextCycle();
    mid();
    serve(vx);

    $display("[TB] cmd_en while busy");
    va = mkVec(0, BR_CMD_READ, 4'd2, 8'h00, {64'h74, 64'h73, 64'h72, 64'h71}, BR_CMD_READ, 4'd2, 8'h00);
    vb = mkVec(0, BR_CMD_WRITE, 4'd9, 8'h99, {64'h93, 64'h92, 64'h91, 64'h90}, BR_CMD_WRITE, 4'd9, 8'h99);
    fork
      applyStimulus(va);
      lateStimulus(5, vb);
    join_none
    waitIssue(4);
    serve(va);
    issues = 0;
    for (int i = 0; i < 12; i++) begin
      mid();
      if (br_cmd_en === 1'b1) issues++;
      nextCycle();
    end
    checkOutput("violation_extra_issues", 64'(issues), 64'd0);
    checkOutput("violation_busy", 64'(busy[0]), 64'd0);

    $display("[TB] reset mid-read");
    va = mkVec(0, BR_CMD_READ, 4'd5, 8'h5A, {64'h84, 64'h83, 64'h82, 64'h81}, BR_CMD_READ, 4'd5, 8'h5A);
    fork applyStimulus(va); join_none
    waitIssue(4);
    checkOutput("rst_seq_issue_addr", 64'(br_addr), 64'd5);
    for (int k = 0; k < 2; k++) begin
      nextCycle();
      br_rd_data_ready = 1'b1;
      br_rd_data       = va.beats[k];
      mid();
      checkOutput("rst_seq_ready", 64'(rdy[0]), 64'd1);
    end
    nextCycle();
    br_rd_data_ready = 1'b0;
    br_rd_data       = '0;
    rst = 1'b1;
    mid();
    checkReset();
    nextCycle();
    rst = 1'b0;
    for (int k = 2; k < 4; k++) begin
      br_rd_data_ready = 1'b1;
      br_rd_data       = va.beats[k];
      mid();
      checkOutput("stray_ready", 64'(rdy), 64'd0);
      checkOutput("stray_cmd_en", 64'(br_cmd_en), 64'd0);
      nextCycle();
    end
    br_rd_data_ready = 1'b0;
    br_rd_data       = '0;
    vb = mkVec(1, BR_CMD_READ, 4'd7, 8'hA5, {64'h94, 64'h93, 64'h92, 64'h91}, BR_CMD_READ, 4'd7, 8'hA5);
    runVector(vb);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
